// File: rtl/id_pipe.sv
// Instruction-decode pipeline stage: decodes one RV32 instruction per transfer
// into a registered operand bundle for EX, with load-use stall and EX flush.
module id_pipe #(
  parameter int XLEN      = 32,
  parameter bit CSR_EN    = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            ex_jump_flag_i,
  output logic [4:0]      regr1_addr_o,
  output logic [4:0]      regr2_addr_o,
  input  logic [XLEN-1:0] reg1_rdata_i,
  input  logic [XLEN-1:0] reg2_rdata_i,
  output logic [11:0]     csrr_addr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] op1_jump_o,
  output logic [XLEN-1:0] op2_jump_o,
  output logic            regw_enable_o,
  output logic [4:0]      regw_addr_o,
  output logic            csrw_enable_o,
  output logic [11:0]     csrw_addr_o,
  output logic            mem_rd_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [3:0] {
    K_ILLEGAL, K_OP_IMM, K_OP, K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_BRANCH, K_LOAD, K_STORE, K_PRIV, K_CSR
  } kind_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] op1_jump;
    logic [XLEN-1:0] op2_jump;
    logic            regw_en;
    logic [4:0]      regw_addr;
    logic            csrw_en;
    logic [11:0]     csrw_addr;
    logic            mem_rd;
    logic            illegal;
  } bundle_t;

  // A bubble carries a canonical NOP and no side effects.
  function automatic bundle_t bubble();
    bundle_t b;
    b      = '0;
    b.inst = NOP;
    return b;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign rd     = inst_i[11:7];

  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign i_imm = XLEN'($signed(inst_i[31:20]));
  assign s_imm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign b_imm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign u_imm = XLEN'($signed({inst_i[31:12], 12'h000}));
  assign j_imm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

  kind_e kind;

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    kind = K_ILLEGAL;
    case (opcode)
      OPC_OP_IMM: kind = K_OP_IMM;
      OPC_OP:     kind = K_OP;
      OPC_LUI:    kind = K_LUI;
      OPC_AUIPC:  kind = K_AUIPC;
      OPC_JAL:    kind = K_JAL;
      OPC_JALR:   kind = K_JALR;
      OPC_BRANCH: kind = K_BRANCH;
      OPC_LOAD:   kind = K_LOAD;
      OPC_STORE:  kind = K_STORE;
      OPC_SYSTEM: begin
        // funct3=000 is ECALL/EBREAK/xRET; funct3=100 is reserved.
        if (CSR_EN) begin
          if (funct3 == 3'b000)      kind = K_PRIV;
          else if (funct3 != 3'b100) kind = K_CSR;
        end
      end
      default:    kind = K_ILLEGAL;
    endcase
  end

  bundle_t dec;
  logic    rs1_used, rs2_used, writes_rd;

  always_comb begin
    dec       = '0;
    dec.inst  = inst_i;
    dec.pc    = inst_addr_i;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    case (kind)
      K_OP_IMM, K_LOAD: begin
        dec.op1 = reg1_rdata_i; dec.op2 = i_imm;
        rs1_used = 1'b1; writes_rd = 1'b1;
      end
      K_STORE: begin
        dec.op1 = reg1_rdata_i; dec.op2 = s_imm;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      K_OP: begin
        dec.op1 = reg1_rdata_i; dec.op2 = reg2_rdata_i;
        rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1;
      end
      K_LUI: begin
        dec.op1 = u_imm; writes_rd = 1'b1;
      end
      K_AUIPC: begin
        dec.op1 = inst_addr_i; dec.op2 = u_imm; writes_rd = 1'b1;
      end
      K_JAL: begin
        dec.op1 = inst_addr_i; dec.op2 = XLEN'(4);
        dec.op1_jump = inst_addr_i; dec.op2_jump = j_imm;
        writes_rd = 1'b1;
      end
      K_JALR: begin
        dec.op1 = inst_addr_i; dec.op2 = XLEN'(4);
        dec.op1_jump = reg1_rdata_i; dec.op2_jump = i_imm;
        rs1_used = 1'b1; writes_rd = 1'b1;
      end
      K_BRANCH: begin
        dec.op1 = reg1_rdata_i; dec.op2 = reg2_rdata_i;
        dec.op1_jump = inst_addr_i; dec.op2_jump = b_imm;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      K_CSR: begin
        // funct3[2] selects the immediate (CSRRxI) form with a 5-bit zimm.
        dec.op1       = csr_rdata_i;
        dec.op2       = funct3[2] ? XLEN'(rs1) : reg1_rdata_i;
        dec.csrw_en   = 1'b1;
        dec.csrw_addr = inst_i[31:20];
        rs1_used      = !funct3[2];
        writes_rd     = 1'b1;
      end
      K_ILLEGAL: dec.illegal = 1'b1;
      default:   ;
    endcase
    dec.regw_en   = writes_rd && (rd != 5'd0);
    dec.regw_addr = dec.regw_en ? rd : 5'd0;
    dec.mem_rd    = (kind == K_LOAD);
  end

  assign regr1_addr_o = rs1_used ? rs1 : 5'd0;
  assign regr2_addr_o = rs2_used ? rs2 : 5'd0;
  assign csrr_addr_o  = (kind == K_CSR) ? inst_i[31:20] : 12'h000;

  bundle_t q;
  logic    valid_q;
  logic    stall;
  logic    issue;

  // Load in EX whose rd feeds the incoming instruction: hold it back one slot.
  assign stall = HAZARD_EN && inst_valid_i && valid_q && q.mem_rd &&
                 (q.regw_addr != 5'd0) &&
                 ((q.regw_addr == regr1_addr_o) || (q.regw_addr == regr2_addr_o));

  assign inst_ready_o = ex_jump_flag_i || ((!valid_q || ex_ready_i) && !stall);
  assign issue        = inst_valid_i && inst_ready_o && !ex_jump_flag_i;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      q       <= bubble();
    end else if (ex_jump_flag_i) begin
      valid_q <= 1'b0;
      q       <= bubble();
    end else if (issue) begin
      valid_q <= 1'b1;
      q       <= dec;
    end else if (!valid_q || ex_ready_i) begin
      valid_q <= 1'b0;
      q       <= bubble();
    end
  end

  assign ex_valid_o    = valid_q;
  assign inst_o        = q.inst;
  assign inst_addr_o   = q.pc;
  assign op1_o         = q.op1;
  assign op2_o         = q.op2;
  assign op1_jump_o    = q.op1_jump;
  assign op2_jump_o    = q.op2_jump;
  assign regw_enable_o = q.regw_en;
  assign regw_addr_o   = q.regw_addr;
  assign csrw_enable_o = q.csrw_en;
  assign csrw_addr_o   = q.csrw_addr;
  assign mem_rd_o      = q.mem_rd;
  assign illegal_o     = q.illegal;

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe
Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath/operand width.
REQ-002 SHALL provide parameter CSR_EN, default 1, 1 = decode SYSTEM/CSR, 0 = treat SYSTEM as illegal.
REQ-003 SHALL provide parameter HAZARD_EN, default 1, 1 = load-use stall logic present.
REQ-004 SHALL provide clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL provide rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL provide inst_valid_i  in  1  fetch presents an instruction.
REQ-007 SHALL provide inst_ready_o  out  1  stage accepts the instruction this cycle.
REQ-008 SHALL provide inst_i  in  32  instruction word.
REQ-009 SHALL provide inst_addr_i  in  XLEN  instruction address.
REQ-010 SHALL provide ex_jump_flag_i  in  1  EX redirect, flush request.
REQ-011 SHALL provide regr1_addr_o  out  5  rs1 read address, combinational.
REQ-012 SHALL provide regr2_addr_o  out  5  rs2 read address, combinational.
REQ-013 SHALL provide reg1_rdata_i  in  XLEN  rs1 data.
REQ-014 SHALL provide reg2_rdata_i  in  XLEN  rs2 data.
REQ-015 SHALL provide csrr_addr_o  out  12  CSR read address, combinational.
REQ-016 SHALL provide csr_rdata_i  in  XLEN  CSR read data.
REQ-017 SHALL provide ex_valid_o  out  1  registered bundle valid to EX.
REQ-018 SHALL provide ex_ready_i  in  1  EX accepts the bundle.
REQ-019 SHALL provide inst_o  out  32  registered instruction.
REQ-020 SHALL provide inst_addr_o  out  XLEN  registered instruction address.
REQ-021 SHALL provide op1_o  out  XLEN  ALU operand 1.
REQ-022 SHALL provide op2_o  out  XLEN  ALU operand 2.
REQ-023 SHALL provide op1_jump_o  out  XLEN  jump/branch target base.
REQ-024 SHALL provide op2_jump_o  out  XLEN  jump/branch target offset.
REQ-025 SHALL provide regw_enable_o  out  1  GPR write enable.
REQ-026 SHALL provide regw_addr_o  out  5  GPR write address (rd).
REQ-027 SHALL provide csrw_enable_o  out  1  CSR write enable.
REQ-028 SHALL provide csrw_addr_o  out  12  CSR write address.
REQ-029 SHALL provide mem_rd_o  out  1  registered instruction is a LOAD.
REQ-030 SHALL provide illegal_o  out  1  registered instruction undecodable.
Function
REQ-031 SHALL decode OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM (CSR_EN=1); any other opcode -> illegal_o=1, regw_enable_o=0, csrw_enable_o=0.
REQ-032 SHALL form operands: OP-IMM/LOAD op1=rs1, op2=sext I-imm; STORE op1=rs1, op2=sext S-imm; OP op1=rs1, op2=rs2; LUI op1=U-imm, op2=0; AUIPC op1=pc, op2=U-imm; all immediates sign-extended to XLEN.
REQ-033 SHALL form jumps: JAL op1=pc, op2=4, jump=pc+J-imm; JALR op1=pc, op2=4, jump=rs1+I-imm; BRANCH op1=rs1, op2=rs2, jump=pc+B-imm; non-jump classes drive jump operands 0.
REQ-034 SHALL for CSR ops drive csrr_addr_o=csrw_addr_o=inst[31:20], op1=csr_rdata_i, op2=rs1 (CSRRx) or zero-extended inst[19:15] (CSRRxI), csrw_enable_o=1.
REQ-035 SHALL set regw_enable_o for OP-IMM, OP, LUI, AUIPC, JAL, JALR, LOAD, CSR, forced 0 when rd=0; regr1/regr2_addr_o = rs1/rs2 only when the class reads them, else 0.
REQ-036 SHALL register one bundle per transfer (inst_valid_i & inst_ready_o), latency 1 cycle, throughput 1 per cycle; inst_ready_o = (!ex_valid_o | ex_ready_i) & !stall.
REQ-037 SHALL hold all registered outputs bit-stable while ex_valid_o=1 and ex_ready_i=0.
REQ-038 SHALL (HAZARD_EN=1) stall when ex_valid_o & mem_rd_o & regw_addr_o!=0 & regw_addr_o equals a used rs1/rs2 of valid inst_i; stall lasts exactly one EX acceptance and inserts one bubble.
REQ-039 SHALL on ex_jump_flag_i=1 clear ex_valid_o at next edge, drop inst_i (inst_ready_o=1, not issued); flush overrides stall and hold.
REQ-040 SHALL drive bubbles (ex_valid_o=0) with regw_enable_o, csrw_enable_o, mem_rd_o, illegal_o = 0 and inst_o=0x00000013.
Reset
REQ-041 SHALL on rst=1 at rising clk clear ex_valid_o and all registered outputs to 0 except inst_o=0x00000013; rst overrides flush, stall, hold, mid-operation included.
Verification
REQ-042 SHALL cover: inst 0xFFB10093 (addi x1,x2,-5), reg1=10 -> next cycle ex_valid_o=1, op1=10, op2=0xFFFFFFFB, regw x1.
REQ-043 SHALL cover: 0x0000A283 (lw x5) then 0x00728333 (add x6,x5,x7) -> inst_ready_o=0 one cycle, one bubble, add issued next.
REQ-044 SHALL cover: ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> outputs constant, inst_ready_o=0.
REQ-045 SHALL cover: ex_jump_flag_i=1 with valid inst_i -> next cycle ex_valid_o=0, that instruction never issued.
REQ-046 SHALL cover: rst pulse mid-stream -> ex_valid_o=0, inst_o=0x13; opcode 0x7F issued -> illegal_o=1, regw_enable_o=0.
